// File: rtl/atm_pkg.sv
// Shared types for the ATM transaction engine: operation codes,
// response status codes and the request-processing FSM states.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_INQUIRY  = 2'b00,
    OP_DEPOSIT  = 2'b01,
    OP_WITHDRAW = 2'b10,
    OP_TRANSFER = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_NSF      = 2'b01,
    ST_OVF      = 2'b10,
    ST_BAD_ACCT = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CALC   = 2'b01,
    S_COMMIT = 2'b10,
    S_RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/bal_addsub.sv
// Unsigned W-bit adder/subtractor; carry is the add carry-out or the
// subtract borrow, taken from bit W of a W+1-bit result.
module bal_addsub #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         carry
);

  logic [W:0] ext_s;

  // Extended-width add or subtract; bit W flags carry or borrow
  always_comb begin
    ext_s = {1'b0, a};
    if (sub) begin
      ext_s = {1'b0, a} - {1'b0, b};
    end else begin
      ext_s = {1'b0, a} + {1'b0, b};
    end
  end

  assign result = ext_s[W-1:0];
  assign carry  = ext_s[W];

endmodule

// File: rtl/atm_txn_engine.sv
// ATM transaction engine: checked read-modify-write of a reset-to-zero
// balance bank, one request at a time through IDLE/CALC/COMMIT/RESP.
module atm_txn_engine
  import atm_pkg::*;
#(
  parameter int BAL_W    = 10,
  parameter int NUM_ACCT = 16,
  parameter int ACCT_W   = $clog2(NUM_ACCT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ACCT_W-1:0] req_acct_s,
  input  logic [ACCT_W-1:0] req_acct_d,
  input  logic [BAL_W-1:0]  req_amount,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [BAL_W-1:0]  rsp_balance,
  output logic [15:0]       txn_count
);

  localparam logic [ACCT_W:0] NUM_ACCT_L = NUM_ACCT[ACCT_W:0];

  state_e              state_r, state_next_s;
  op_e                 op_r;
  logic [ACCT_W-1:0]   acct_s_r, acct_d_r;
  logic [BAL_W-1:0]    amount_r;
  logic [BAL_W-1:0]    bal_r [NUM_ACCT];

  status_e             calc_status_r;
  logic [BAL_W-1:0]    res_s_r, res_d_r, calc_rsp_bal_r;

  logic                req_ready_r, rsp_valid_r;
  status_e             rsp_status_r;
  logic [BAL_W-1:0]    rsp_balance_r;
  logic [15:0]         txn_count_r;

  logic                accept_s, rsp_done_s;
  logic                s_ok_s, d_ok_s, bad_acct_s;
  logic [BAL_W-1:0]    bal_s_s, bal_d_s, add_a_s;
  logic [BAL_W-1:0]    sub_res_s, add_res_s, new_s_s, rsp_bal_s;
  logic                sub_borrow_s, add_carry_s;
  status_e             status_s;

  assign accept_s   = (state_r == S_IDLE) && req_valid && req_ready_r;
  assign rsp_done_s = (state_r == S_RESP) && rsp_ready;

  // Account range checks; out-of-range reads are forced to zero
  always_comb begin
    s_ok_s     = ({1'b0, acct_s_r} < NUM_ACCT_L);
    d_ok_s     = ({1'b0, acct_d_r} < NUM_ACCT_L);
    bad_acct_s = !s_ok_s ||
                 ((op_r == OP_TRANSFER) && (!d_ok_s || (acct_d_r == acct_s_r)));
    if (s_ok_s) begin
      bal_s_s = bal_r[acct_s_r];
    end else begin
      bal_s_s = {BAL_W{1'b0}};
    end
    if (d_ok_s) begin
      bal_d_s = bal_r[acct_d_r];
    end else begin
      bal_d_s = {BAL_W{1'b0}};
    end
    if (op_r == OP_TRANSFER) begin
      add_a_s = bal_d_s;
    end else begin
      add_a_s = bal_s_s;
    end
  end

  bal_addsub #(.W(BAL_W)) u_src (
    .a      (bal_s_s),
    .b      (amount_r),
    .sub    (1'b1),
    .result (sub_res_s),
    .carry  (sub_borrow_s)
  );

  // The destination adder also serves DEPOSIT, where it adds to bal[s]
  bal_addsub #(.W(BAL_W)) u_dst (
    .a      (add_a_s),
    .b      (amount_r),
    .sub    (1'b0),
    .result (add_res_s),
    .carry  (add_carry_s)
  );

  // Status priority and post-operation source balance
  always_comb begin
    status_s  = ST_OK;
    new_s_s   = bal_s_s;
    rsp_bal_s = bal_s_s;
    if (bad_acct_s) begin
      status_s  = ST_BAD_ACCT;
      rsp_bal_s = {BAL_W{1'b0}};
    end else if (((op_r == OP_WITHDRAW) || (op_r == OP_TRANSFER)) && sub_borrow_s) begin
      status_s = ST_NSF;
    end else if (((op_r == OP_DEPOSIT) || (op_r == OP_TRANSFER)) && add_carry_s) begin
      status_s = ST_OVF;
    end else begin
      status_s = ST_OK;
      case (op_r)
        OP_INQUIRY:  new_s_s = bal_s_s;
        OP_DEPOSIT:  new_s_s = add_res_s;
        OP_WITHDRAW: new_s_s = sub_res_s;
        OP_TRANSFER: new_s_s = sub_res_s;
        default:     new_s_s = bal_s_s;
      endcase
      rsp_bal_s = new_s_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_next_s = S_CALC;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_CALC:   state_next_s = S_COMMIT;
      S_COMMIT: state_next_s = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_RESP;
        end
      end
      default:  state_next_s = S_IDLE;
    endcase
  end

  // Request latch and CALC-stage result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r           <= OP_INQUIRY;
      acct_s_r       <= {ACCT_W{1'b0}};
      acct_d_r       <= {ACCT_W{1'b0}};
      amount_r       <= {BAL_W{1'b0}};
      calc_status_r  <= ST_OK;
      res_s_r        <= {BAL_W{1'b0}};
      res_d_r        <= {BAL_W{1'b0}};
      calc_rsp_bal_r <= {BAL_W{1'b0}};
    end else if (accept_s) begin
      op_r     <= op_e'(req_op);
      acct_s_r <= req_acct_s;
      acct_d_r <= req_acct_d;
      amount_r <= req_amount;
    end else if (state_r == S_CALC) begin
      calc_status_r  <= status_s;
      res_s_r        <= new_s_s;
      res_d_r        <= add_res_s;
      calc_rsp_bal_r <= rsp_bal_s;
    end
  end

  // Balance bank: both transfer legs commit on the same edge, only when OK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCT; i++) begin
        bal_r[i] <= {BAL_W{1'b0}};
      end
    end else if ((state_r == S_COMMIT) && (calc_status_r == ST_OK)) begin
      case (op_r)
        OP_DEPOSIT:  bal_r[acct_s_r] <= res_s_r;
        OP_WITHDRAW: bal_r[acct_s_r] <= res_s_r;
        OP_TRANSFER: begin
          bal_r[acct_s_r] <= res_s_r;
          bal_r[acct_d_r] <= res_d_r;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags, response registers and OK-transaction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_status_r  <= ST_OK;
      rsp_balance_r <= {BAL_W{1'b0}};
      txn_count_r   <= 16'd0;
    end else if (accept_s) begin
      req_ready_r <= 1'b0;
    end else if (state_r == S_COMMIT) begin
      rsp_valid_r   <= 1'b1;
      rsp_status_r  <= calc_status_r;
      rsp_balance_r <= calc_rsp_bal_r;
      if (calc_status_r == ST_OK) begin
        txn_count_r <= txn_count_r + 16'd1;
      end else begin
        txn_count_r <= txn_count_r;
      end
    end else if (rsp_done_s) begin
      rsp_valid_r <= 1'b0;
      req_ready_r <= 1'b1;
    end
  end

  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_status  = rsp_status_r;
  assign rsp_balance = rsp_balance_r;
  assign txn_count   = txn_count_r;

endmodule

// File: tb/tb_atm_txn_engine.sv
// Self-checking bench for atm_txn_engine: directed scenarios followed by
// random transactions scored against an account-level reference model.
module tb_atm_txn_engine;

  localparam int BAL_W    = 10;
  localparam int NUM_ACCT = 12;
  localparam int ACCT_W   = 4;
  localparam int MAX_BAL  = (1 << BAL_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ACCT_W-1:0] req_acct_s;
  logic [ACCT_W-1:0] req_acct_d;
  logic [BAL_W-1:0]  req_amount;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_status;
  logic [BAL_W-1:0]  rsp_balance;
  logic [15:0]       txn_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_bal [NUM_ACCT];
  int model_txn;

  atm_txn_engine #(.BAL_W(BAL_W), .NUM_ACCT(NUM_ACCT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_acct_s  (req_acct_s),
    .req_acct_d  (req_acct_d),
    .req_amount  (req_amount),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_status  (rsp_status),
    .rsp_balance (rsp_balance),
    .txn_count   (txn_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ACCT; i++) model_bal[i] = 0;
    model_txn = 0;
  endtask

  // Expected status/balance straight from the account rules
  task automatic model_apply(input int op, input int s, input int d, input int amt,
                             output int exp_st, output int exp_bal);
    if (s >= NUM_ACCT || (op == 3 && (d >= NUM_ACCT || d == s))) begin
      exp_st = 3; exp_bal = 0;
    end else if ((op == 2 || op == 3) && amt > model_bal[s]) begin
      exp_st = 1; exp_bal = model_bal[s];
    end else if ((op == 1 && model_bal[s] + amt > MAX_BAL) ||
                 (op == 3 && model_bal[d] + amt > MAX_BAL)) begin
      exp_st = 2; exp_bal = model_bal[s];
    end else begin
      exp_st = 0;
      if (op == 1) model_bal[s] += amt;
      if (op == 2) model_bal[s] -= amt;
      if (op == 3) begin
        model_bal[s] -= amt;
        model_bal[d] += amt;
      end
      exp_bal = model_bal[s];
      model_txn = (model_txn + 1) % 65536;
    end
  endtask

  task automatic run_txn(input int op, input int s, input int d, input int amt, input int hold);
    int exp_st, exp_bal, cnt;
    model_apply(op, s, d, amt, exp_st, exp_bal);
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = op[1:0];
    req_acct_s = s[ACCT_W-1:0];
    req_acct_d = d[ACCT_W-1:0];
    req_amount = amt[BAL_W-1:0];
    rsp_ready  = (hold == 0);
    cnt = 0;
    while (req_ready !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid  = 1'b0;
    req_op     = 2'($urandom_range(0, 3));
    req_amount = BAL_W'($urandom_range(0, MAX_BAL));
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("rsp_latency", cnt, 32'd2);
    chk("rsp_status", {30'd0, rsp_status}, exp_st);
    chk("rsp_balance", {22'd0, rsp_balance}, exp_bal);
    chk("txn_count", {16'd0, txn_count}, model_txn);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_status", {30'd0, rsp_status}, exp_st);
      chk("hold_balance", {22'd0, rsp_balance}, exp_bal);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, req_ready}, 32'd1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int op, s, d, amt;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_acct_s = 4'd0;
    req_acct_d = 4'd0; req_amount = 10'd0; rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
    chk("rst_rsp_balance", {22'd0, rsp_balance}, 32'd0);
    chk("rst_txn_count", {16'd0, txn_count}, 32'd0);
    rst_n = 1'b1;

    run_txn(0, 4, 0, 0, 0);
    run_txn(1, 4, 0, 200, 0);
    run_txn(1, 2, 0, 100, 0);
    run_txn(3, 4, 2, 150, 0);
    run_txn(0, 2, 0, 0, 0);
    run_txn(2, 4, 0, 60, 0);
    run_txn(2, 4, 0, 50, 0);
    run_txn(1, 2, 0, 1000, 0);
    run_txn(1, 2, 0, 773, 0);
    run_txn(3, 2, 2, 10, 0);
    run_txn(0, 13, 0, 0, 0);
    run_txn(3, 4, 13, 0, 0);
    run_txn(3, 3, 2, 0, 0);
    run_txn(1, 3, 0, 5, 0);
    run_txn(3, 3, 2, 1, 0);
    run_txn(0, 2, 0, 0, 5);

    for (int k = 0; k < 80; k++) begin
      op  = $urandom_range(0, 3);
      s   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NUM_ACCT - 1);
      d   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NUM_ACCT - 1);
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_BAL) : $urandom_range(0, 300);
      run_txn(op, s, d, amt, $urandom_range(0, 2));
    end

    // Reset while a transfer sits in COMMIT
    run_txn(1, 5, 0, 500, 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd3; req_acct_s = 4'd5; req_acct_d = 4'd6;
    req_amount = 10'd100; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_txn_count", {16'd0, txn_count}, 32'd0);
    chk("midrst_rsp_balance", {22'd0, rsp_balance}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    chk("postrst_req_ready", {31'd0, req_ready}, 32'd1);
    for (int a = 0; a < NUM_ACCT; a++) run_txn(0, a, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/atm_txn_engine.md
# atm_txn_engine

Parametrised ATM transaction engine. It holds a bank of account balances and executes four operations, one request at a time: inquiry, deposit, withdraw and transfer. It is the sequential core that sits behind the ATM front-end select/amount inputs. It replaces the fixed 16×10-bit balance array and its bare adder with a checked read-modify-write engine. Insufficient funds, overflow and bad accounts are detected in hardware and reported in the response.

## Interface
- BAL_W, 10, balance and amount width in bits (unsigned)
- NUM_ACCT, 16, number of accounts (≥2, need not be a power of 2)
- ACCT_W, $clog2(NUM_ACCT), account index width (derived; do not override)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine can accept a request
- req_op  in  2  00 INQUIRY, 01 DEPOSIT, 10 WITHDRAW, 11 TRANSFER
- req_acct_s  in  ACCT_W  source/target account (all ops)
- req_acct_d  in  ACCT_W  destination account (TRANSFER only)
- req_amount  in  BAL_W  amount (ignored for INQUIRY)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_status  out  2  00 OK, 01 NSF, 10 OVF, 11 BAD_ACCT
- rsp_balance  out  BAL_W  balance of req_acct_s after the operation
- txn_count  out  16  count of OK transactions, wraps at 2^16

## Operation
- FSM states: IDLE → CALC → COMMIT → RESP → IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op, accounts and amount, then go to CALC.
- CALC: read bal[s] and bal[d], compute results and status, register both.
- COMMIT: write balances only if status is OK, increment txn_count if OK, then go to RESP.
- RESP: rsp_valid=1. Hold status and balance stable until rsp_ready, then go to IDLE.
- Status rules, evaluated in priority order:
  - BAD_ACCT: s ≥ NUM_ACCT, or (TRANSFER and (d ≥ NUM_ACCT or d==s)).
  - NSF: WITHDRAW or TRANSFER with amount > bal[s].
  - OVF: DEPOSIT with bal[s]+amount > 2^BAL_W−1, or TRANSFER with bal[d]+amount > 2^BAL_W−1.
  - Otherwise OK.
- Arithmetic is unsigned BAL_W bits. The carry-out (add) or borrow (sub) of a BAL_W+1-bit result drives OVF/NSF. Balances never wrap or saturate.
- Effects of each op when status is OK:
  - INQUIRY: no write.
  - DEPOSIT: bal[s]+=amount.
  - WITHDRAW: bal[s]−=amount.
  - TRANSFER: bal[s]−=amount and bal[d]+=amount, both in the same COMMIT edge.
- On any non-OK status, no balance changes. rsp_balance is the unchanged bal[s], or 0 on BAD_ACCT.
- Amount 0 is legal for every op and returns OK (BAD_ACCT still applies).

## Timing
- Reset (asynchronous, any state): FSM=IDLE, all balances=0, txn_count=0, req_ready=1, rsp_valid=0, rsp_status=00, rsp_balance=0.
- A reset arriving mid-COMMIT wins: no partial transfer persists, and every balance reads 0.
- Request accepted at edge E0 → CALC during E0..E1 → COMMIT write at E2 → rsp_valid=1 after E2.
- Minimum request-to-request period is 4 cycles. With rsp_ready held high, rsp_valid is high for exactly 1 cycle.
- req_ready is 0 from E0 until the cycle after the response handshake.
- Requests presented while req_ready=0 are neither latched nor lost; the requester holds them.
- Back-to-back requests to the same account always see the previous committed balance, so no bypass is needed.

## Structure
- Package atm_pkg holds:
  - the op enum (INQUIRY/DEPOSIT/WITHDRAW/TRANSFER),
  - the status enum (OK/NSF/OVF/BAD_ACCT),
  - the FSM state enum.
- Sub-module bal_addsub (parameter W) is the parametrised successor of the fixed 10-bit adder.
  - Inputs: a, b, sub.
  - Outputs: W-bit result and carry/borrow.
  - It is instantiated twice: source path (sub) and destination path (add).
- The balance array is a flop array with an async reset. Do not infer RAM; a reset to 0 is required.

## Test plan
- Reset, then INQUIRY acct 4 → OK, rsp_balance 0, txn_count 1.
- DEPOSIT 200→acct 4, DEPOSIT 100→acct 2, TRANSFER 4→2 amount 150 → OK, rsp_balance 50; a following INQUIRY of acct 2 returns 250.
- WITHDRAW 60 from acct 4 (balance 50) → NSF, balance stays 50, txn_count unchanged. WITHDRAW 50 → OK, balance 0.
- DEPOSIT 1000 to acct 2 (balance 250, BAL_W=10) → OVF, balance 250. DEPOSIT 773 → OK, balance 1023.
- TRANSFER 2→2 → BAD_ACCT, rsp_balance 0. With NUM_ACCT=12, INQUIRY acct 13 → BAD_ACCT.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and data stay stable, req_ready=0. Pull rst_n low during COMMIT of a transfer → all balances 0 and rsp_valid=0 immediately; req_ready=1 after release.
